sphere_search_ctrl: RTL

//  Depth-first tree-search sequencer for the 4-level, 3-bit-symbol sphere decoder.

---
 rtl/sd_pkg.sv | 22 ++
 rtl/sphere_search_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
//  Shared definitions for the 4-level, 3-bit-symbol sphere decoder.
//  SYM_W    symbol width in bits
//  NUM_LVL  number of tree levels (level NUM_LVL-1 is the root)
//  SYM_MAX  last symbol value at any level
//  state_t  tree-search sequencer states
// -----------------------------------------------------------------------------
package sd_pkg;

   localparam int                SYM_W   = 3;
   localparam int                NUM_LVL = 4;
   localparam logic [SYM_W-1:0]  SYM_MAX = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      POP,
      FINISH
   } state_t;

endpackage

// File: rtl/sphere_search_ctrl.sv
// -----------------------------------------------------------------------------
// sphere_search_ctrl
//  Depth-first tree-search sequencer for the sphere decoder. Presents one node
//  hypothesis (symbols S_3..S_0 plus level) per cycle to the combinational
//  metric_calc datapath, samples the returned node cost in the same cycle,
//  prunes against the current radius, shrinks the radius on every accepted
//  leaf and reports the best leaf found.
//
//  Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        launch a search (ignored while busy)
//   init_radius  initial squared radius, latched on start
//   node_cost    cost of the node currently presented
//   S_0..S_3     symbol hypotheses (registered)
//   node_lvl     level of the node currently presented (registered)
//   busy         search in progress
//   done         one-cycle pulse at the end of a search
//   found        at least one leaf accepted
//   best_sym     {S_3,S_2,S_1,S_0} of the best leaf
//   best_cost    cost of the best leaf
//   node_count   evaluations in the last or current search
// -----------------------------------------------------------------------------
module sphere_search_ctrl
   import sd_pkg::*;
#(
   parameter int WIDTH     = 20,
   parameter int MAX_NODES = 0,
   parameter int CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WIDTH-1:0]       init_radius,
   input  logic [WIDTH-1:0]       node_cost,
   output logic [SYM_W-1:0]       S_0,
   output logic [SYM_W-1:0]       S_1,
   output logic [SYM_W-1:0]       S_2,
   output logic [SYM_W-1:0]       S_3,
   output logic [1:0]             node_lvl,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic [4*SYM_W-1:0]     best_sym,
   output logic [WIDTH-1:0]       best_cost,
   output logic [CNT_W-1:0]       node_count
);

   state_t            state;
   logic [SYM_W-1:0]  sym [NUM_LVL];
   logic [WIDTH-1:0]  radius;

   // Next-sibling / pop helper
   logic [SYM_W-1:0]  cur_sym;
   logic [SYM_W-1:0]  sib_sym;
   logic              sib_avail;
   logic              at_root;
   logic [1:0]        up_lvl;
   logic [1:0]        dn_lvl;
   logic [CNT_W-1:0]  cnt_inc;
   logic              budget_hit;
   logic              below;
   logic              descend;
   state_t            adv_state;

   always_comb begin
      cur_sym    = sym[node_lvl];
      sib_avail  = (cur_sym != SYM_MAX);
      sib_sym    = cur_sym + SYM_W'(1);
      at_root    = (node_lvl == 2'(NUM_LVL - 1));
      up_lvl     = node_lvl + 2'd1;
      dn_lvl     = node_lvl - 2'd1;
      cnt_inc    = (&node_count) ? node_count : node_count + CNT_W'(1);
      budget_hit = (MAX_NODES != 0) && (cnt_inc == CNT_W'(MAX_NODES));
      below      = (node_cost < radius);
      descend    = below && (node_lvl != 2'd0);
      // Where "move to the next sibling" leads: another evaluation, one level
      // up (one POP cycle per exhausted level), or the end of the tree.
      if (sib_avail)
         adv_state = EVAL;
      else if (at_root)
         adv_state = FINISH;
      else
         adv_state = POP;
   end

   assign S_0 = sym[0];
   assign S_1 = sym[1];
   assign S_2 = sym[2];
   assign S_3 = sym[3];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         for (int i = 0; i < NUM_LVL; i++) sym[i] <= '0;
         node_lvl   <= 2'(NUM_LVL - 1);
         radius     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         found      <= 1'b0;
         best_sym   <= '0;
         best_cost  <= '1;
         node_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  radius     <= init_radius;
                  for (int i = 0; i < NUM_LVL; i++) sym[i] <= '0;
                  node_lvl   <= 2'(NUM_LVL - 1);
                  node_count <= '0;
                  found      <= 1'b0;
                  best_cost  <= '1;
                  busy       <= 1'b1;
                  state      <= EVAL;
               end
            end

            EVAL: begin
               node_count <= cnt_inc;
               if (descend) begin
                  node_lvl    <= dn_lvl;
                  sym[dn_lvl] <= '0;
               end else if (below) begin
                  // Accepted leaf: it becomes the new sphere radius.
                  radius    <= node_cost;
                  best_cost <= node_cost;
                  best_sym  <= {sym[3], sym[2], sym[1], sym[0]};
                  found     <= 1'b1;
               end

               // The budget stop overrides both descend and advance, but the
               // node's own accept/prune above still takes effect.
               if (budget_hit) begin
                  state <= FINISH;
                  done  <= 1'b1;
               end else if (!descend) begin
                  if (sib_avail)
                     sym[node_lvl] <= sib_sym;
                  else if (!at_root)
                     node_lvl <= up_lvl;
                  state <= adv_state;
                  done  <= (adv_state == FINISH);
               end
            end

            POP: begin
               if (sib_avail)
                  sym[node_lvl] <= sib_sym;
               else if (!at_root)
                  node_lvl <= up_lvl;
               state <= adv_state;
               done  <= (adv_state == FINISH);
            end

            FINISH: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
